// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin merge of PORTS FWFT FIFOs into one downstream write port
// Optional burst hold on the current grant is enabled with `define FIFO_ARB_BURST_EN.
module fifo_rr_arbiter #(
    parameter int PORTS     = 4,
    parameter int bits      = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PORTS-1:0]             src_not_empty,
    input  logic [PORTS-1:0][bits-1:0]   src_data,
    output logic [PORTS-1:0]             src_shift_out,
    input  logic                         dst_full,
    output logic                         dst_shift_in,
    output logic [bits-1:0]              dst_data,
    output logic [$clog2(PORTS)-1:0]     dst_port,
    output logic [$clog2(PORTS)-1:0]     grant
);

    localparam int PW = $clog2(PORTS);

    logic          out_valid;
    logic          load;
    logic          found;
    logic [PW-1:0] winner;
    logic [PW:0]   cand_sum;
`ifdef FIFO_ARB_BURST_EN
    logic [7:0]    burst_cnt;
    logic          hold;
`endif

    assign dst_shift_in = out_valid && !dst_full;
    assign load         = !out_valid || dst_shift_in;

    // Search grant+1 .. grant+PORTS (grant itself last), wrapping at PORTS so
    // ids >= PORTS never appear for non-power-of-2 port counts.
    always_comb begin
        found    = 1'b0;
        winner   = grant;
        cand_sum = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand_sum = {1'b0, grant} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(PORTS))
                cand_sum = cand_sum - (PW+1)'(PORTS);
            if (!found && src_not_empty[cand_sum[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[PW-1:0];
            end
        end
`ifdef FIFO_ARB_BURST_EN
        hold = (burst_cnt < 8'(BURST_LEN)) && src_not_empty[grant];
        if (hold) begin
            found  = 1'b1;
            winner = grant;
        end
`endif
    end

    always_comb begin
        src_shift_out = '0;
        if (load && found && !reset)
            src_shift_out[winner] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dst_data  <= '0;
            dst_port  <= '0;
            grant     <= PW'(PORTS - 1);
`ifdef FIFO_ARB_BURST_EN
            // Saturated so the first arbitration after reset is a normal search.
            burst_cnt <= 8'(BURST_LEN);
`endif
        end else if (load) begin
            if (found) begin
                out_valid <= 1'b1;
                dst_data  <= src_data[winner];
                dst_port  <= winner;
                grant     <= winner;
`ifdef FIFO_ARB_BURST_EN
                burst_cnt <= hold ? burst_cnt + 8'd1 : 8'd1;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter against a queue-based reference model
module tb_fifo_rr_arbiter;

    localparam int PORTS = 4;
    localparam int BITS  = 8;
`ifdef FIFO_ARB_BURST_EN
    localparam int BLEN = 2;
`else
    localparam int BLEN = 1;
`endif

    logic                       clk = 1'b0;
    logic                       reset;
    logic [PORTS-1:0]           src_not_empty;
    logic [PORTS-1:0][BITS-1:0] src_data;
    logic [PORTS-1:0]           src_shift_out;
    logic                       dst_full;
    logic                       dst_shift_in;
    logic [BITS-1:0]            dst_data;
    logic [1:0]                 dst_port;
    logic [1:0]                 grant;

    fifo_rr_arbiter #(.PORTS(PORTS), .bits(BITS), .BURST_LEN(BLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .src_not_empty (src_not_empty),
        .src_data      (src_data),
        .src_shift_out (src_shift_out),
        .dst_full      (dst_full),
        .dst_shift_in  (dst_shift_in),
        .dst_data      (dst_data),
        .dst_port      (dst_port),
        .grant         (grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // srcq: words still inside each source FIFO; sent: words of each port not yet pushed downstream
    logic [7:0] srcq [PORTS][$];
    logic [7:0] sent [PORTS][$];
    logic [7:0] pushdata [$];
    int         pushport [$];
    int         pushcyc  [$];
    int         waitc    [PORTS];
    int         cycle = 0;

    bit         m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    int         m_port  = 0;
    int         m_grant = PORTS - 1;
    int         m_cnt   = BLEN;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_sources();
        for (int p = 0; p < PORTS; p++) begin
            src_not_empty[p] = srcq[p].size() > 0;
            src_data[p]      = (srcq[p].size() > 0) ? srcq[p][0] : 8'h00;
        end
    endtask

    task automatic add_word(input int p, input logic [7:0] w);
        srcq[p].push_back(w);
        sent[p].push_back(w);
    endtask

    function automatic void pick(output bit fnd, output int w, output bit hold);
        fnd = 1'b0; w = 0; hold = 1'b0;
`ifdef FIFO_ARB_BURST_EN
        if (m_cnt < BLEN && srcq[m_grant].size() > 0) begin
            fnd = 1'b1; w = m_grant; hold = 1'b1;
            return;
        end
`endif
        for (int k = 1; k <= PORTS; k++) begin
            int p;
            p = (m_grant + k) % PORTS;
            if (!fnd && srcq[p].size() > 0) begin
                fnd = 1'b1; w = p;
            end
        end
    endfunction

    function automatic bit busy();
        busy = m_valid;
        for (int p = 0; p < PORTS; p++)
            if (srcq[p].size() > 0) busy = 1'b1;
    endfunction

    task automatic step(input bit full);
        bit fnd, hold, exp_push, ld, a_push;
        int w, a_port;
        logic [PORTS-1:0] exp_shift, a_shift;
        logic [7:0] a_data, w_data;
        @(negedge clk);
        dst_full = full;
        drive_sources();
        #1;
        exp_push = m_valid && !full;
        ld       = !m_valid || exp_push;
        pick(fnd, w, hold);
        exp_shift = '0;
        if (ld && fnd) exp_shift[w] = 1'b1;
        check("src_shift_out", 32'(src_shift_out), 32'(exp_shift));
        check("dst_shift_in", 32'(dst_shift_in), 32'(exp_push));
        check("grant", 32'(grant), m_grant);
        if (m_valid) begin
            check("dst_data", 32'(dst_data), 32'(m_data));
            check("dst_port", 32'(dst_port), m_port);
        end
        a_shift = src_shift_out;
        a_push  = dst_shift_in;
        a_data  = dst_data;
        a_port  = int'(dst_port);
        w_data  = fnd ? srcq[w][0] : 8'h00;
        @(posedge clk);
        cycle++;
        if (a_push) begin
            if (sent[a_port].size() == 0) check("duplicate", 32'(a_data), 32'hffff_ffff);
            else check("order", 32'(a_data), 32'(sent[a_port].pop_front()));
            pushdata.push_back(a_data);
            pushport.push_back(a_port);
            pushcyc.push_back(cycle);
            for (int p = 0; p < PORTS; p++) begin
                if (p == a_port || srcq[p].size() == 0) waitc[p] = 0;
                else waitc[p]++;
                check("starvation", 32'(waitc[p] <= PORTS * BLEN), 32'd1);
            end
        end
        for (int p = 0; p < PORTS; p++)
            if (a_shift[p]) begin
                if (srcq[p].size() == 0) check("pop_empty", 32'(p), 32'hffff_ffff);
                else void'(srcq[p].pop_front());
            end
        if (ld) begin
            if (fnd) begin
                m_valid = 1'b1; m_data = w_data; m_port = w; m_grant = w;
                m_cnt   = hold ? m_cnt + 1 : 1;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(negedge clk);
        reset = 1'b1;
        drive_sources();
        #1;
        if (m_valid) void'(sent[m_port].pop_front());
        m_valid = 1'b0; m_data = '0; m_port = 0; m_grant = PORTS - 1; m_cnt = BLEN;
        for (int p = 0; p < PORTS; p++) waitc[p] = 0;
        check("rst_dst_shift_in", 32'(dst_shift_in), 32'd0);
        check("rst_dst_data", 32'(dst_data), 32'd0);
        check("rst_dst_port", 32'(dst_port), 32'd0);
        check("rst_grant", 32'(grant), PORTS - 1);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            #1;
            check("rst_src_shift_out", 32'(src_shift_out), 32'd0);
            check("rst_dst_shift_in", 32'(dst_shift_in), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (busy() && n < bound) begin
            step(1'b0);
            n++;
        end
        check("drain_timeout", 32'(busy()), 32'd0);
    endtask

    task automatic clear_logs();
        pushdata.delete(); pushport.delete(); pushcyc.delete();
    endtask

    task automatic run_until_pushes(input int n, input int bound);
        int c = 0;
        while (pushport.size() < n && c < bound) begin
            step(1'b0);
            c++;
        end
        check("push_count", 32'(pushport.size()), 32'(n));
    endtask

    initial begin
        int exp_seq [12];
        int cnt31;
        reset = 1'b1; dst_full = 1'b0; src_not_empty = '0; src_data = '0;
        for (int p = 0; p < PORTS; p++) waitc[p] = 0;

        // idle after reset
        do_reset(3);
        for (int i = 0; i < 10; i++) step(1'b0);
        #1;
        check("idle_dst_data", 32'(dst_data), 32'd0);
        check("idle_grant", 32'(grant), 32'd3);

        // all ports hold three words
        for (int p = 0; p < PORTS; p++)
            for (int n = 0; n < 3; n++) add_word(p, 8'((p << 4) + n));
        clear_logs();
`ifdef FIFO_ARB_BURST_EN
        exp_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
        run_until_pushes(12, 40);
        for (int i = 0; i < 12; i++) begin
            check("seq_port", 32'(pushport[i]), 32'(exp_seq[i]));
            check("seq_gapfree", 32'(pushcyc[i] - pushcyc[0]), 32'(i));
        end
        drain(50);

        // downstream full holds the slot
        add_word(2, 8'h20); add_word(2, 8'h21);
        step(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            #1 check("full_hold_data", 32'(dst_data), 32'h20);
        end
        clear_logs();
        step(1'b0);
        step(1'b0);
        check("release_count", 32'(pushdata.size()), 32'd2);
        check("release_first", 32'(pushdata[0]), 32'h20);
        check("release_second", 32'(pushdata[1]), 32'h21);
        check("release_gap", 32'(pushcyc[1] - pushcyc[0]), 32'd1);
        drain(20);

        // single busy port streams without gaps
        for (int n = 0; n < 6; n++) add_word(2, 8'(8'h40 + n));
        clear_logs();
        run_until_pushes(6, 20);
        for (int i = 0; i < 6; i++) begin
            check("solo_port", 32'(pushport[i]), 32'd2);
            check("solo_gapfree", 32'(pushcyc[i] - pushcyc[0]), 32'(i));
        end
        drain(20);

        // reset with a loaded word discards it
        add_word(3, 8'h31);
        clear_logs();
        step(1'b1);
        add_word(0, 8'h07); add_word(3, 8'h32);
        do_reset(2);
        step(1'b0);
        #1 check("post_reset_grant", 32'(grant), 32'd0);
        drain(20);
        cnt31 = 0;
        foreach (pushdata[i]) if (pushdata[i] == 8'h31) cnt31++;
        check("discarded_word", 32'(cnt31), 32'd0);

        // randomized traffic
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                int p;
                p = $urandom_range(0, PORTS - 1);
                if (srcq[p].size() < 6) add_word(p, 8'($urandom));
            end
            step($urandom_range(0, 3) == 0);
        end
        drain(200);
        for (int p = 0; p < PORTS; p++)
            check("leftover", 32'(sent[p].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
